// File: rtl/escalonador_contextos.sv
// Round-robin context scheduler for the preemptive multitasking datapath.
// It keeps a bitmap of ready user contexts and counts the quantum of the running one.
// It asks the instruction injector for a context switch and holds the target steady
// until the injector acknowledges. Context 0 is the OS and is never picked from the bitmap.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OCIOSO    | no user context to run; waits for the bitmap to become non-empty
// EXECUTA   | a context is running; the quantum counter advances
// SELECIONA | one cycle that runs the round-robin search on the bitmap
// TROCA     | switch requested (preempta=1); waits for troca_ack
module escalonador_contextos #(
    parameter int N_CTX   = 8,
    parameter int QUANTUM = 80,
    localparam int IDX_W  = $clog2(N_CTX),
    localparam int CNT_W  = $clog2(QUANTUM) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ctx_atual,
    input  logic             cria_valid,
    input  logic [IDX_W-1:0] cria_ctx,
    input  logic             fim_valid,
    input  logic             troca_ack,
    output logic             preempta,
    output logic [31:0]      prox_ctx,
    output logic             ocioso,
    output logic [N_CTX-1:0] prontos
);

    typedef enum logic [1:0] {OCIOSO, EXECUTA, SELECIONA, TROCA} estado_t;

    localparam logic [CNT_W-1:0] ULTIMO_CICLO = CNT_W'(QUANTUM - 1);

    estado_t          estado, estado_n;
    logic [CNT_W-1:0] contador, contador_n;
    logic [IDX_W-1:0] ultimo, ultimo_n;
    logic [IDX_W-1:0] prox_reg, prox_n;
    logic [N_CTX-1:0] prontos_n;
    logic             achou;
    logic [IDX_W-1:0] alvo;

    // Ready bitmap update: create wins over terminate on the same index; bit 0 stays clear.
    always_comb begin
        prontos_n = prontos;
        if (fim_valid && ctx_atual != 32'd0)
            prontos_n[ctx_atual[IDX_W-1:0]] = 1'b0;
        if (cria_valid && cria_ctx != '0)
            prontos_n[cria_ctx] = 1'b1;
        prontos_n[0] = 1'b0;
    end

    // Round-robin search starting after ultimo, wrapping, and visiting ultimo itself last.
    always_comb begin
        achou = 1'b0;
        alvo  = '0;
        for (int i = 1; i <= N_CTX; i++) begin
            int idx;
            idx = int'(ultimo) + i;
            if (idx >= N_CTX)
                idx = idx - N_CTX;
            if (!achou && idx != 0 && prontos[IDX_W'(idx)]) begin
                achou = 1'b1;
                alvo  = IDX_W'(idx);
            end
        end
    end

    // Next-state logic for the scheduler FSM and its counter/target registers.
    always_comb begin
        estado_n   = estado;
        contador_n = contador;
        prox_n     = prox_reg;
        ultimo_n   = ultimo;
        case (estado)
            OCIOSO: begin
                contador_n = '0;
                if (prontos != '0)
                    estado_n = SELECIONA;
            end
            EXECUTA: begin
                if (fim_valid || contador == ULTIMO_CICLO)
                    estado_n = SELECIONA;
                else if (ctx_atual != 32'd0)
                    contador_n = contador + 1'b1;
            end
            SELECIONA: begin
                if (achou && 32'(alvo) != ctx_atual) begin
                    prox_n   = alvo;
                    ultimo_n = alvo;
                    estado_n = TROCA;
                end else if (achou) begin
                    // Sole ready context keeps running; record it as last served so
                    // the rotation continues from it once others become ready.
                    ultimo_n   = alvo;
                    contador_n = '0;
                    estado_n   = EXECUTA;
                end else begin
                    prox_n   = '0;
                    estado_n = TROCA;
                end
            end
            TROCA: begin
                if (troca_ack) begin
                    contador_n = '0;
                    estado_n   = (prox_reg == '0) ? OCIOSO : EXECUTA;
                end
            end
            default: estado_n = OCIOSO;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= OCIOSO;
            contador <= '0;
            ultimo   <= '0;
            prox_reg <= '0;
            prontos  <= '0;
        end else begin
            estado   <= estado_n;
            contador <= contador_n;
            ultimo   <= ultimo_n;
            prox_reg <= prox_n;
            prontos  <= prontos_n;
        end
    end

    assign preempta = (estado == TROCA);
    assign prox_ctx = 32'(prox_reg);
    assign ocioso   = (prontos == '0);

endmodule

// File: tb/tb_escalonador_contextos.sv
// Directed bench for the round-robin context scheduler.
module tb_escalonador_contextos;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ctx_atual = 32'd0;
    logic        cria_valid = 1'b0;
    logic [2:0]  cria_ctx = 3'd0;
    logic        fim_valid = 1'b0;
    logic        troca_ack = 1'b0;
    logic        preempta;
    logic [31:0] prox_ctx;
    logic        ocioso;
    logic [7:0]  prontos;

    int assertions = 0;
    int failures   = 0;

    escalonador_contextos #(.N_CTX(8), .QUANTUM(80)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctx_atual  (ctx_atual),
        .cria_valid (cria_valid),
        .cria_ctx   (cria_ctx),
        .fim_valid  (fim_valid),
        .troca_ack  (troca_ack),
        .preempta   (preempta),
        .prox_ctx   (prox_ctx),
        .ocioso     (ocioso),
        .prontos    (prontos)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cria_valid = 1'b0; fim_valid = 1'b0; troca_ack = 1'b0;
        ctx_atual = 32'd0; cria_ctx = 3'd0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic ack(input logic [31:0] novo_ctx);
        troca_ack = 1'b1;
        ctx_atual = novo_ctx;
        tick(1);
        troca_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        assertions++;
        if (preempta !== 1'b0) begin failures++; $display("FAIL reset_preempta got %b exp 0", preempta); end
        assertions++;
        if (prox_ctx !== 32'd0) begin failures++; $display("FAIL reset_prox got %0d exp 0", prox_ctx); end
        assertions++;
        if (ocioso !== 1'b1) begin failures++; $display("FAIL reset_ocioso got %b exp 1", ocioso); end
        assertions++;
        if (prontos !== 8'h00) begin failures++; $display("FAIL reset_prontos got %h exp 00", prontos); end
    endtask

    task automatic test_self_reselect();
        int altos;
        altos = 0;
        ctx_atual = 32'd1;
        cria_valid = 1'b1; cria_ctx = 3'd1;
        tick(1);
        cria_valid = 1'b0;
        assertions++;
        if (prontos !== 8'h02) begin failures++; $display("FAIL self_prontos got %h exp 02", prontos); end
        tick(2);
        assertions++;
        if (dut.contador !== 8'd0) begin failures++; $display("FAIL self_cnt_start got %0d exp 0", dut.contador); end
        for (int i = 0; i < 79; i++) begin
            tick(1);
            if (preempta !== 1'b0) altos++;
        end
        assertions++;
        if (dut.contador !== 8'd79) begin failures++; $display("FAIL self_cnt_last got %0d exp 79", dut.contador); end
        tick(1);
        if (preempta !== 1'b0) altos++;
        tick(1);
        if (preempta !== 1'b0) altos++;
        assertions++;
        if (dut.contador !== 8'd0) begin failures++; $display("FAIL self_cnt_restart got %0d exp 0", dut.contador); end
        assertions++;
        if (altos !== 0) begin failures++; $display("FAIL self_no_preempt got %0d high cycles exp 0", altos); end
    endtask

    task automatic test_round_robin();
        int n;
        bit ok;
        cria_valid = 1'b1; cria_ctx = 3'd2;
        tick(1);
        cria_ctx = 3'd3;
        tick(1);
        cria_valid = 1'b0;
        assertions++;
        if (prontos !== 8'h0E) begin failures++; $display("FAIL rr_prontos got %h exp 0e", prontos); end
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (dut.contador === 8'd79) ok = 1'b1;
            else tick(1);
        end
        assertions++;
        if (!ok) begin failures++; $display("FAIL rr_quantum_timeout got %0d exp 79", dut.contador); end
        tick(1);
        assertions++;
        if (preempta !== 1'b0) begin failures++; $display("FAIL rr_latency1 got %b exp 0", preempta); end
        tick(1);
        assertions++;
        if (preempta !== 1'b1 || prox_ctx !== 32'd2) begin
            failures++; $display("FAIL rr_first got preempta=%b prox=%0d exp 1/2", preempta, prox_ctx);
        end
        cria_valid = 1'b1; cria_ctx = 3'd5;
        tick(1);
        cria_valid = 1'b0;
        assertions++;
        if (prox_ctx !== 32'd2) begin failures++; $display("FAIL rr_frozen got %0d exp 2", prox_ctx); end
        fim_valid = 1'b1; ctx_atual = 32'd5;
        tick(1);
        fim_valid = 1'b0; ctx_atual = 32'd1;
        ack(32'd2);
        assertions++;
        if (preempta !== 1'b0) begin failures++; $display("FAIL rr_ack got %b exp 0", preempta); end
        n = 0;
        while (preempta !== 1'b1 && n < 300) begin tick(1); n++; end
        assertions++;
        if (n !== 81 || prox_ctx !== 32'd3) begin
            failures++; $display("FAIL rr_second got cycles=%0d prox=%0d exp 81/3", n, prox_ctx);
        end
        ack(32'd3);
        n = 0;
        while (preempta !== 1'b1 && n < 300) begin tick(1); n++; end
        assertions++;
        if (n !== 81 || prox_ctx !== 32'd1) begin
            failures++; $display("FAIL rr_wrap got cycles=%0d prox=%0d exp 81/1", n, prox_ctx);
        end
    endtask

    task automatic test_fim();
        int n;
        ack(32'd1);
        n = 0;
        while (preempta !== 1'b1 && n < 300) begin tick(1); n++; end
        assertions++;
        if (prox_ctx !== 32'd2) begin failures++; $display("FAIL fim_setup got %0d exp 2", prox_ctx); end
        ack(32'd2);
        tick(5);
        fim_valid = 1'b1;
        tick(1);
        fim_valid = 1'b0;
        assertions++;
        if (prontos[2] !== 1'b0 || preempta !== 1'b0) begin
            failures++; $display("FAIL fim_clear got prontos=%h preempta=%b exp bit2=0/0", prontos, preempta);
        end
        tick(1);
        assertions++;
        if (preempta !== 1'b1 || prox_ctx !== 32'd3) begin
            failures++; $display("FAIL fim_next got preempta=%b prox=%0d exp 1/3", preempta, prox_ctx);
        end
    endtask

    task automatic test_return_os();
        do_reset();
        cria_valid = 1'b1; cria_ctx = 3'd4;
        tick(1);
        cria_valid = 1'b0;
        tick(2);
        assertions++;
        if (preempta !== 1'b1 || prox_ctx !== 32'd4) begin
            failures++; $display("FAIL os_start got preempta=%b prox=%0d exp 1/4", preempta, prox_ctx);
        end
        ack(32'd4);
        tick(3);
        fim_valid = 1'b1;
        tick(1);
        fim_valid = 1'b0;
        assertions++;
        if (ocioso !== 1'b1 || prontos !== 8'h00) begin
            failures++; $display("FAIL os_empty got ocioso=%b prontos=%h exp 1/00", ocioso, prontos);
        end
        tick(1);
        assertions++;
        if (preempta !== 1'b1 || prox_ctx !== 32'd0) begin
            failures++; $display("FAIL os_target got preempta=%b prox=%0d exp 1/0", preempta, prox_ctx);
        end
        ack(32'd0);
        tick(3);
        assertions++;
        if (preempta !== 1'b0 || ocioso !== 1'b1) begin
            failures++; $display("FAIL os_idle got preempta=%b ocioso=%b exp 0/1", preempta, ocioso);
        end
    endtask

    task automatic test_set_wins();
        ctx_atual = 32'd5;
        cria_valid = 1'b1; cria_ctx = 3'd5;
        tick(1);
        fim_valid = 1'b1;
        tick(1);
        cria_valid = 1'b0;
        assertions++;
        if (prontos !== 8'h20) begin failures++; $display("FAIL set_wins got %h exp 20", prontos); end
        tick(1);
        fim_valid = 1'b0;
        assertions++;
        if (prontos !== 8'h00) begin failures++; $display("FAIL fim_alone got %h exp 00", prontos); end
        cria_valid = 1'b1; cria_ctx = 3'd0;
        tick(1);
        cria_valid = 1'b0;
        assertions++;
        if (prontos !== 8'h00) begin failures++; $display("FAIL cria_zero got %h exp 00", prontos); end
    endtask

    task automatic test_reset_in_troca();
        do_reset();
        cria_valid = 1'b1; cria_ctx = 3'd6;
        tick(1);
        cria_valid = 1'b0;
        tick(2);
        assertions++;
        if (preempta !== 1'b1 || prox_ctx !== 32'd6) begin
            failures++; $display("FAIL rst_setup got preempta=%b prox=%0d exp 1/6", preempta, prox_ctx);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        assertions++;
        if (preempta !== 1'b0 || prontos !== 8'h00 || prox_ctx !== 32'd0 || ocioso !== 1'b1) begin
            failures++;
            $display("FAIL rst_abort got preempta=%b prontos=%h prox=%0d ocioso=%b exp 0/00/0/1",
                     preempta, prontos, prox_ctx, ocioso);
        end
    endtask

    initial begin
        test_reset();
        test_self_reselect();
        test_round_robin();
        test_fim();
        test_return_os();
        test_set_wins();
        test_reset_in_troca();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
